mp64_dma_arb: RTL and testbench
===============================

Name: mp64_dma_arb

Overview:
- Round-robin arbiter sharing one byte-wide DMA memory port among NUM_M byte-DMA masters (NIC, disk, other peripherals).
- Masters use the req/addr/wdata/wen -> rdata/ack handshake. Each master holds req steady until it sees ack.
- Sits between the peripheral DMA ports and the system memory interface.
- Supports bounded bursts so one master cannot starve the others.

Parameters:
- NUM_M, 2, number of masters (2..8).
- IDW, 3, width of gnt_id; must satisfy 2**IDW >= NUM_M.
- MAX_BURST, 16, byte transfers a master may complete per grant while another master is waiting (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- m_req  in  NUM_M  per-master request, held until ack.
- m_addr  in  64*NUM_M  per-master byte address; slice k is bits [64k+63:64k].
- m_wdata  in  8*NUM_M  per-master write data.
- m_wen  in  NUM_M  per-master write enable; 0 means read.
- m_rdata  out  8  read data, broadcast to all masters (equals mem_rdata).
- m_ack  out  NUM_M  per-master ack; only the granted bit can be 1.
- mem_req  out  1  memory request.
- mem_addr  out  64  memory address.
- mem_wdata  out  8  memory write data.
- mem_wen  out  1  memory write enable.
- mem_rdata  in  8  memory read data.
- mem_ack  in  1  memory ack; may be combinational (same cycle as mem_req) or delayed.
- gnt_valid  out  1  a master currently owns the port.
- gnt_id  out  IDW  index of the owning master (valid when gnt_valid=1).

Behaviour:
- States: IDLE and OWN. Registers:
  - gnt (IDW bits): current owner.
  - last (IDW bits): most recent owner.
  - bcnt (8 bits): transfers completed in this grant.
- Reset (rst=1 at a clk edge):
  - state=IDLE, gnt=0, last=NUM_M-1 (so master 0 wins first), bcnt=0.
  - Outputs during and after reset: mem_req=0, m_ack=0, gnt_valid=0, gnt_id=0.
  - If rst is asserted mid-transfer, mem_req drops the cycle after the reset edge. The in-flight transfer is abandoned and no ack is forwarded.
- IDLE:
  - mem_req=0, all m_ack=0.
  - If any m_req is set, select the first requester searching (last+1), (last+2), ... modulo NUM_M.
  - At the next edge: state=OWN, gnt=selected, bcnt=0.
  - Latency: m_req rises in cycle t -> mem_req=1 in cycle t+1. There is a one-cycle bubble on every grant change.
- OWN, combinational:
  - mem_req = m_req[gnt].
  - mem_addr / mem_wdata / mem_wen = slice gnt of the corresponding master bus.
  - m_ack[gnt] = mem_ack & m_req[gnt]; all other m_ack bits = 0.
  - m_rdata = mem_rdata at all times.
  - gnt_valid=1, gnt_id=gnt.
- OWN, at each edge:
  - If m_req[gnt]=1 and mem_ack=1: bcnt saturates-increments. Then, if the new bcnt >= MAX_BURST and any other m_req bit is set, go to IDLE with last=gnt. Otherwise stay in OWN.
  - If m_req[gnt]=0: the master is between bytes or finished. Go to IDLE with last=gnt.
  - Otherwise (request waiting on ack): stay. A transfer is never preempted before its ack.
- Masters that drop req on ack and re-raise it one cycle later lose ownership each byte. Fairness still holds through the round-robin pointer.
- A sole requester is never cut off by MAX_BURST. bcnt saturates at 255 and does not wrap.
- Arbitration uses only the m_req value sampled at the decision edge. A request arriving in the same cycle as a release is considered in the next IDLE.
- Non-owner masters never see ack and their buses are ignored, even if they change mid-grant.
- NUM_M=1 degenerates to a pass-through with a one-cycle bubble per IDLE entry.

Test Plan:
1. Apply reset, hold rst 3 cycles with m_req=2'b11 -> mem_req=0, m_ack=0, gnt_valid=0 throughout. The first edge after rst deasserts selects master 0; mem_req=1 one cycle later.
2. Master 0 requests alone with m_addr=0x4000, m_wen=1, m_wdata=0xAA; memory uses combinational ack -> mem_addr=0x4000, mem_wdata=0xAA, m_ack=2'b01 in the same cycle as mem_req. Only master 0 ever sees ack.
3. Masters 0 and 1 both request continuously (req held, combinational ack), MAX_BURST=4 -> 4 acks to master 0, then 1 idle cycle, then 4 to master 1, alternating. Check for 64 cycles.
4. Master 0 holds req with no competitor for 300 transfers -> never loses grant. bcnt stays at 255 with no wrap.
5. Memory ack delayed 3 cycles while master 1 requests -> master 0 keeps the grant and mem_addr is stable until ack. Master 1 is granted after master 0 releases.
6. Assert rst during a pending write with ack not yet given -> mem_req=0 the next cycle, no ack forwarded, gnt_valid=0, and master 0 wins the first grant after reset.

Source files
------------

// File: rtl/mp64_dma_arb.sv
// mp64_dma_arb: round-robin arbiter sharing one byte-wide DMA memory port among NUM_M masters
module mp64_dma_arb #(
  parameter int NUM_M     = 2,
  parameter int IDW       = 3,
  parameter int MAX_BURST = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_M-1:0]      m_req,
  input  logic [64*NUM_M-1:0]   m_addr,
  input  logic [8*NUM_M-1:0]    m_wdata,
  input  logic [NUM_M-1:0]      m_wen,
  output logic [7:0]            m_rdata,
  output logic [NUM_M-1:0]      m_ack,
  output logic                  mem_req,
  output logic [63:0]           mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_wen,
  input  logic [7:0]            mem_rdata,
  input  logic                  mem_ack,
  output logic                  gnt_valid,
  output logic [IDW-1:0]        gnt_id
);
  typedef enum logic {IDLE, OWN} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] gnt_q, gnt_d, last_q, last_d, sel;
  logic [7:0] bcnt_q, bcnt_d, bcnt_inc;
  logic cur_req, other, found, own, done, rel;
  assign own       = state_q == OWN;
  assign mem_req   = own & cur_req;
  assign m_rdata   = mem_rdata;
  assign gnt_valid = own;
  assign gnt_id    = gnt_q;
  assign bcnt_inc  = (bcnt_q == 8'hFF) ? bcnt_q : bcnt_q + 8'd1;
  assign done      = cur_req & mem_ack;
  assign rel       = !cur_req || (done && bcnt_inc >= 8'(MAX_BURST) && other);
  always_comb begin
    cur_req   = 1'b0;
    other     = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    m_ack     = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (gnt_q == IDW'(k)) begin
        cur_req   = m_req[k];
        mem_addr  = m_addr[64*k +: 64];
        mem_wdata = m_wdata[8*k +: 8];
        mem_wen   = m_wen[k];
        m_ack[k]  = own & mem_ack & m_req[k];
      end else begin
        other = other | m_req[k];
      end
    end
  end
  always_comb begin
    sel   = last_q;
    found = 1'b0;
    for (int i = 1; i <= NUM_M; i++) begin
      for (int k = 0; k < NUM_M; k++) begin
        if (!found && m_req[k] && k == (int'(last_q) + i) % NUM_M) begin
          sel   = IDW'(k);
          found = 1'b1;
        end
      end
    end
  end
  always_comb begin
    state_d = own ? (rel ? IDLE : OWN) : (|m_req ? OWN : IDLE);
    gnt_d   = (!own && |m_req) ? sel : gnt_q;
    last_d  = (own && rel) ? gnt_q : last_q;
    bcnt_d  = !own ? 8'd0 : (done ? bcnt_inc : bcnt_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IDW'(NUM_M - 1);
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
    end
  end
endmodule

// File: tb/tb_mp64_dma_arb.sv
// tb_mp64_dma_arb: directed self-checking bench for the DMA round-robin arbiter
module tb_mp64_dma_arb;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   m_req = '0;
  logic [127:0] m_addr = '0;
  logic [15:0]  m_wdata = '0;
  logic [1:0]   m_wen = '0;
  logic [7:0]   m_rdata;
  logic [1:0]   m_ack;
  logic         mem_req;
  logic [63:0]  mem_addr;
  logic [7:0]   mem_wdata;
  logic         mem_wen;
  logic [7:0]   mem_rdata = 8'h5C;
  logic         mem_ack;
  logic         gnt_valid;
  logic [2:0]   gnt_id;
  logic         ack_comb = 1'b0;
  logic         ack_force = 1'b0;
  int           tests = 0;
  int           fails = 0;
  assign mem_ack = ack_comb ? mem_req : ack_force;
  always #5 clk = ~clk;
  mp64_dma_arb #(.NUM_M(2), .IDW(3), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wen(m_wen), .m_rdata(m_rdata), .m_ack(m_ack), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .gnt_valid(gnt_valid), .gnt_id(gnt_id)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic apply_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask
  task automatic test_reset;
    ack_comb = 1'b0;
    ack_force = 1'b0;
    m_req = 2'b11;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      tests++;
      if ({mem_req, m_ack, gnt_valid} !== 4'b0000) begin
        fails++;
        $display("FAIL reset_hold[%0d]: mem_req=%b m_ack=%b gnt_valid=%b, want all 0", i, mem_req, m_ack, gnt_valid);
      end
    end
    rst = 1'b0;
    #1;
    tests++;
    if (mem_req !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle_cycle: mem_req=%b want 0", mem_req);
    end
    tick;
    tests++;
    if ({mem_req, gnt_valid, gnt_id} !== {1'b1, 1'b1, 3'd0}) begin
      fails++;
      $display("FAIL reset_first_grant: mem_req=%b gnt_valid=%b gnt_id=%0d want 1 1 0", mem_req, gnt_valid, gnt_id);
    end
    m_req = 2'b00;
    tick;
    tick;
  endtask
  task automatic test_single_write;
    m_req = 2'b00;
    apply_reset;
    ack_comb = 1'b1;
    m_addr = {64'hDEAD_BEEF_0000_0001, 64'h0000_0000_0000_4000};
    m_wdata = 16'h55AA;
    m_wen = 2'b01;
    m_req = 2'b01;
    #1;
    tests++;
    if (mem_req !== 1'b0) begin
      fails++;
      $display("FAIL single_bubble: mem_req=%b want 0", mem_req);
    end
    tick;
    tests++;
    if ({mem_req, mem_addr, mem_wdata, mem_wen, m_ack, m_rdata} !== {1'b1, 64'h4000, 8'hAA, 1'b1, 2'b01, 8'h5C}) begin
      fails++;
      $display("FAIL single_write: req=%b addr=%h wdata=%h wen=%b ack=%b rdata=%h want 1 4000 aa 1 01 5c",
               mem_req, mem_addr, mem_wdata, mem_wen, m_ack, m_rdata);
    end
    for (int i = 0; i < 3; i++) begin
      m_addr[127:64] = 64'h1234 + 64'(i);
      tick;
      tests++;
      if ({m_ack, mem_addr} !== {2'b01, 64'h4000}) begin
        fails++;
        $display("FAIL single_hold[%0d]: ack=%b addr=%h want 01 4000", i, m_ack, mem_addr);
      end
    end
    m_req = 2'b00;
    tick;
    tick;
  endtask
  task automatic test_burst_alternation;
    logic [1:0] exp;
    m_req = 2'b11;
    ack_comb = 1'b1;
    apply_reset;
    for (int c = 0; c < 64; c++) begin
      exp = (c % 5 == 0) ? 2'b00 : (((c / 5) % 2 == 0) ? 2'b01 : 2'b10);
      #1;
      tests++;
      if (m_ack !== exp) begin
        fails++;
        $display("FAIL burst_cycle[%0d]: m_ack=%b want %b", c, m_ack, exp);
      end
      tick;
    end
    m_req = 2'b00;
    tick;
    tick;
  endtask
  task automatic test_sole_requester;
    int acks;
    int lost;
    acks = 0;
    lost = 0;
    m_req = 2'b01;
    ack_comb = 1'b1;
    apply_reset;
    tick;
    for (int i = 0; i < 300; i++) begin
      if (m_ack == 2'b01) acks++;
      if (!gnt_valid || gnt_id != 3'd0) lost++;
      tick;
    end
    tests++;
    if (acks !== 300) begin
      fails++;
      $display("FAIL sole_acks: got %0d want 300", acks);
    end
    tests++;
    if (lost !== 0) begin
      fails++;
      $display("FAIL sole_grant_lost: got %0d cycles want 0", lost);
    end
    tests++;
    if (dut.bcnt_q !== 8'd255) begin
      fails++;
      $display("FAIL sole_bcnt_sat: got %0d want 255", dut.bcnt_q);
    end
    m_req = 2'b00;
    tick;
    tick;
  endtask
  task automatic test_delayed_ack;
    ack_comb = 1'b0;
    ack_force = 1'b0;
    m_req = 2'b00;
    apply_reset;
    m_addr = {64'h9000, 64'h8000};
    m_wen = 2'b00;
    m_req = 2'b11;
    tick;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if ({mem_req, mem_addr, m_ack, gnt_id} !== {1'b1, 64'h8000, 2'b00, 3'd0}) begin
        fails++;
        $display("FAIL delay_wait[%0d]: req=%b addr=%h ack=%b id=%0d want 1 8000 00 0", i, mem_req, mem_addr, m_ack, gnt_id);
      end
      m_addr[127:64] = 64'h9000 + 64'(i);
      tick;
    end
    ack_force = 1'b1;
    #1;
    tests++;
    if ({m_ack, m_rdata} !== {2'b01, 8'h5C}) begin
      fails++;
      $display("FAIL delay_ack: ack=%b rdata=%h want 01 5c", m_ack, m_rdata);
    end
    tick;
    m_req = 2'b10;
    ack_force = 1'b0;
    #1;
    tests++;
    if ({mem_req, m_ack} !== 3'b000) begin
      fails++;
      $display("FAIL delay_release: req=%b ack=%b want 0 00", mem_req, m_ack);
    end
    tick;
    tests++;
    if (gnt_valid !== 1'b0) begin
      fails++;
      $display("FAIL delay_bubble: gnt_valid=%b want 0", gnt_valid);
    end
    tick;
    tests++;
    if ({gnt_valid, gnt_id, mem_addr} !== {1'b1, 3'd1, 64'h9002}) begin
      fails++;
      $display("FAIL delay_handover: valid=%b id=%0d addr=%h want 1 1 9002", gnt_valid, gnt_id, mem_addr);
    end
    ack_force = 1'b1;
    #1;
    tests++;
    if (m_ack !== 2'b10) begin
      fails++;
      $display("FAIL delay_m1_ack: ack=%b want 10", m_ack);
    end
    tick;
    m_req = 2'b00;
    ack_force = 1'b0;
    tick;
    tick;
  endtask
  task automatic test_reset_mid_transfer;
    ack_comb = 1'b0;
    ack_force = 1'b0;
    m_req = 2'b01;
    apply_reset;
    tick;
    m_req = 2'b00;
    tick;
    m_req = 2'b10;
    m_wen = 2'b10;
    tick;
    tests++;
    if ({gnt_id, mem_req, mem_wen} !== {3'd1, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL midrst_setup: id=%0d req=%b wen=%b want 1 1 1", gnt_id, mem_req, mem_wen);
    end
    rst = 1'b1;
    m_req = 2'b11;
    tick;
    ack_force = 1'b1;
    #1;
    tests++;
    if ({mem_req, m_ack, gnt_valid, gnt_id} !== 7'b0) begin
      fails++;
      $display("FAIL midrst_abort: req=%b ack=%b valid=%b id=%0d want 0 00 0 0", mem_req, m_ack, gnt_valid, gnt_id);
    end
    rst = 1'b0;
    ack_force = 1'b0;
    tick;
    tests++;
    if ({gnt_valid, gnt_id} !== {1'b1, 3'd0}) begin
      fails++;
      $display("FAIL midrst_regrant: valid=%b id=%0d want 1 0", gnt_valid, gnt_id);
    end
    m_req = 2'b00;
    tick;
    tick;
  endtask
  initial begin
    test_reset;
    test_single_write;
    test_burst_alternation;
    test_sole_requester;
    test_delayed_ack;
    test_reset_mid_transfer;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
